// File: rtl/pathfinder_pkg.sv
// Shared pathfinder definitions: arg-min FSM states, the accelerator's
// "no distance" marker value, and default datapath widths.
package pathfinder_pkg;

  // Default widths, shared with the accelerator wrapper
  localparam int DEFAULT_DIST_WIDTH = 32;
  localparam int DEFAULT_ID_WIDTH   = 8;

  // Marker the accelerator emits for an unreachable/invalid distance
  localparam logic [31:0] DIST_INVALID = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } argmin_state_t;

endpackage

// File: rtl/dist_argmin.sv
// Streaming arg-min over a batch of (distance, node id) pairs. Tracks the
// smallest valid (non-marker) distance and its id, then flags completion with
// a level interrupt that software acknowledges.
module dist_argmin
  import pathfinder_pkg::*;
#(
  parameter int DIST_WIDTH = DEFAULT_DIST_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ID_WIDTH-1:0]   batch_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIST_WIDTH-1:0] in_dist,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  busy,
  output logic [DIST_WIDTH-1:0] min_dist,
  output logic [ID_WIDTH-1:0]   min_id,
  output logic                  found,
  output logic [ID_WIDTH-1:0]   count,
  output logic                  done_irq,
  input  logic                  irq_ack
);

  // All-ones at the configured width; equals DIST_INVALID at the default width
  localparam logic [DIST_WIDTH-1:0] DIST_ALL_ONES = '1;

  argmin_state_t       state;
  logic [ID_WIDTH-1:0] len_latched;
  logic [ID_WIDTH-1:0] count_inc;
  logic                dist_is_invalid;
  logic                take_new_min;

  // Handshake and status come straight from the state register
  assign in_ready = (state == ACTIVE);
  assign busy     = (state == ACTIVE);

  assign count_inc       = count + ID_WIDTH'(1);
  assign dist_is_invalid = (in_dist == DIST_ALL_ONES);
  // Strict compare keeps the earliest pair on ties
  assign take_new_min    = !dist_is_invalid && (!found || (in_dist < min_dist));

  // Batch FSM with registered results and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_latched <= '0;
      min_dist    <= DIST_ALL_ONES;
      min_id      <= '0;
      found       <= 1'b0;
      count       <= '0;
      done_irq    <= 1'b0;
    end else begin
      // Acknowledge first so any set below in the same cycle wins
      if (irq_ack) begin
        done_irq <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_latched <= batch_len;
            min_dist    <= DIST_ALL_ONES;
            min_id      <= '0;
            found       <= 1'b0;
            count       <= '0;
            if (batch_len == '0) begin
              // Nothing to consume: complete immediately
              state    <= DONE;
              done_irq <= 1'b1;
            end else begin
              state    <= ACTIVE;
              done_irq <= 1'b0;
            end
          end else if ((state == DONE) && irq_ack) begin
            state <= IDLE;
          end
        end

        ACTIVE: begin
          // start is ignored here; only transfers advance the batch
          if (in_valid) begin
            count <= count_inc;
            if (take_new_min) begin
              min_dist <= in_dist;
              min_id   <= in_id;
              found    <= 1'b1;
            end
            if (count_inc == len_latched) begin
              state    <= DONE;
              done_irq <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dist_argmin.sv
// Directed bench for dist_argmin. Stimulus pushes the hand-computed batch
// result into a queue; a monitor pops and checks it on each done_irq rise.
module tb_dist_argmin;

  localparam int DW = 32;
  localparam int IW = 8;
  localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;

  typedef struct {
    logic [DW-1:0] min_dist;
    logic [IW-1:0] min_id;
    logic          found;
    logic [IW-1:0] count;
  } result_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] batch_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dist = '0;
  logic [IW-1:0] in_id = '0;
  logic          busy;
  logic [DW-1:0] min_dist;
  logic [IW-1:0] min_id;
  logic          found;
  logic [IW-1:0] count;
  logic          done_irq;
  logic          irq_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  result_t exp_q[$];
  bit stim_done = 1'b0;

  dist_argmin #(.DIST_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .batch_len(batch_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_id(in_id),
    .busy(busy), .min_dist(min_dist), .min_id(min_id), .found(found),
    .count(count), .done_irq(done_irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [DW-1:0] d, input logic [IW-1:0] id,
                               input logic f, input logic [IW-1:0] c);
    result_t r;
    r.min_dist = d; r.min_id = id; r.found = f; r.count = c;
    exp_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [IW-1:0] len);
    start = 1'b1; batch_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  // Present one pair and hold it until the handshake edge (bounded wait)
  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id);
    int waited;
    in_dist = d; in_id = id; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    step();
    in_valid = 1'b0;
    $display("tb: sent dist=%0h id=%0d count_after=%0d", d, id, count);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: compare against the scoreboard on each rising done_irq
  initial begin : monitor
    logic prev_irq;
    result_t e;
    prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (done_irq && !prev_irq) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=done_irq_rise required=no_batch_pending");
        end else begin
          e = exp_q.pop_front();
          $display("tb: batch done min_dist=%0h min_id=%0d found=%0d count=%0d",
                   min_dist, min_id, found, count);
          check("res_min_dist", 64'(min_dist), 64'(e.min_dist));
          check("res_min_id",   64'(min_id),   64'(e.min_id));
          check("res_found",    64'(found),    64'(e.found));
          check("res_count",    64'(count),    64'(e.count));
        end
      end
      prev_irq = done_irq;
    end
  end

  initial begin : stimulus
    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_min_dist", 64'(min_dist), 64'(ONES));
    check("rst_min_id",   64'(min_id),   64'(0));
    check("rst_found",    64'(found),    64'(0));
    check("rst_count",    64'(count),    64'(0));
    check("rst_done_irq", 64'(done_irq), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Reset mid-batch after 2 of 4 transfers
    pulse_start(8'd4);
    send(32'd5, 8'd1);
    send(32'd6, 8'd2);
    check("mid_count_before_rst", 64'(count), 64'(2));
    check("mid_min_before_rst", 64'(min_dist), 64'(5));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",     64'(busy),     64'(0));
    check("mid_rst_min_dist", 64'(min_dist), 64'(ONES));
    check("mid_rst_count",    64'(count),    64'(0));
    check("mid_rst_found",    64'(found),    64'(0));
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    idle(3);
    check("post_rst_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;

    // Basic batch, tie keeps earliest
    expect_result(32'd20, 8'd2, 1'b1, 8'd4);
    pulse_start(8'd4);
    check("start_in_ready", 64'(in_ready), 64'(1));
    send(32'd50, 8'd1);
    send(32'd20, 8'd2);
    send(32'd35, 8'd3);
    check("basic_no_irq_early", 64'(done_irq), 64'(0));
    send(32'd20, 8'd4);
    check("basic_irq_n_plus_1", 64'(done_irq), 64'(1));
    check("basic_busy_done", 64'(busy), 64'(0));
    pulse_ack();
    check("ack_clears_irq", 64'(done_irq), 64'(0));
    check("ack_holds_min", 64'(min_dist), 64'(20));

    // All-invalid batch, no gaps
    expect_result(ONES, 8'd0, 1'b0, 8'd3);
    pulse_start(8'd3);
    send(ONES, 8'd7);
    send(ONES, 8'd8);
    send(ONES, 8'd9);
    pulse_ack();

    // Same batch with in_valid gaps of 0-3 cycles
    expect_result(ONES, 8'd0, 1'b0, 8'd3);
    pulse_start(8'd3);
    idle(2);
    send(ONES, 8'd7);
    idle(3);
    send(ONES, 8'd8);
    send(ONES, 8'd9);
    pulse_ack();

    // Zero-length batch
    expect_result(ONES, 8'd0, 1'b0, 8'd0);
    pulse_start(8'd0);
    check("zero_done_irq",  64'(done_irq), 64'(1));
    check("zero_in_ready",  64'(in_ready), 64'(0));
    check("zero_busy",      64'(busy),     64'(0));
    @(negedge clk);
    pulse_ack();

    // start during ACTIVE is ignored
    expect_result(32'd30, 8'd1, 1'b1, 8'd2);
    pulse_start(8'd2);
    send(32'd30, 8'd1);
    pulse_start(8'd7);
    check("restart_ignored_count", 64'(count), 64'(1));
    send(32'd40, 8'd2);
    check("restart_ignored_done", 64'(done_irq), 64'(1));
    pulse_ack();

    // irq_ack on the DONE-entry edge: set wins
    expect_result(32'd9, 8'd5, 1'b1, 8'd1);
    pulse_start(8'd1);
    in_dist = 32'd9; in_id = 8'd5; in_valid = 1'b1; irq_ack = 1'b1;
    step();
    in_valid = 1'b0; irq_ack = 1'b0;
    check("ack_on_entry_irq", 64'(done_irq), 64'(1));

    // start with irq_ack in DONE: start wins
    expect_result(32'd7, 8'd2, 1'b1, 8'd2);
    irq_ack = 1'b1;
    pulse_start(8'd2);
    irq_ack = 1'b0;
    check("start_ack_irq",   64'(done_irq), 64'(0));
    check("start_ack_busy",  64'(busy),     64'(1));
    check("start_ack_found", 64'(found),    64'(0));
    check("start_ack_min",   64'(min_dist), 64'(ONES));
    send(32'd100, 8'd1);
    send(32'd7, 8'd2);
    pulse_ack();

    // Back-to-back: B must not inherit A's minimum
    expect_result(32'd10, 8'd3, 1'b1, 8'd3);
    pulse_start(8'd3);
    send(32'd15, 8'd1);
    send(32'd10, 8'd3);
    send(32'd12, 8'd4);
    pulse_ack();
    expect_result(32'd11, 8'd1, 1'b1, 8'd3);
    pulse_start(8'd3);
    send(32'd11, 8'd1);
    send(32'd30, 8'd2);
    send(32'd11, 8'd5);
    idle(2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #200000;
    if (!stim_done) begin
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
